// File: rtl/uart_rx.sv
// Purpose : UART receiver; 1 line bit per clock, 8N? frame = start, WIDTH data LSB first, even parity, stop.
// Latency : start bit sampled on rx at edge E0 -> data_valid high after edge E0+WIDTH+4.
// Backpr. : none on the line; an unacked word is overwritten and flagged by sticky overrun.
module uart_rx #(
  parameter int WIDTH = 8
) (
  input  logic             rx_clk,
  input  logic             rx_reset,
  input  logic             rx,
  input  logic             rx_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             rx_busy
);

  localparam int CW = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             pe_q, pe_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             commit;

  // FSM state register.
  always_ff @(posedge rx_clk or negedge rx_reset) begin
    if (!rx_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Synchronizer, shift/count datapath and output word register.
  // Synchronizer resets to idle-high so releasing reset never looks like a start bit.
  always_ff @(posedge rx_clk or negedge rx_reset) begin
    if (!rx_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      count_q   <= '0;
      shift_q   <= '0;
      pe_q      <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      pe_q      <= pe_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state, frame assembly, commit on STOP, and host handshake (commit beats ack).
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    pe_d      = pe_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    commit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = DATA;
          count_d = '0;
        end
      end
      DATA: begin
        shift_d = {rx_s_q, shift_q[WIDTH-1:1]};
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = PARITY;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      PARITY: begin
        // Even parity: received bit XOR data bits is nonzero on mismatch.
        pe_d    = rx_s_q ^ (^shift_q);
        state_d = STOP;
      end
      STOP: begin
        commit  = 1'b1;
        data_d  = shift_q;
        valid_d = 1'b1;
        perr_d  = pe_q;
        ferr_d  = ~rx_s_q;
        ovr_d   = ovr_q | (valid_q & ~rx_ack);
        state_d = rx_s_q ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!commit && rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive stage directly downstream of UART_TX. It consumes the serial line UART_TX drives and returns parallel words to the host side.
- Runs on the same clock as the transmitter, one line bit per clock; there is no baud divider and no oversampling.
- Frame format: start bit 0, WIDTH data bits LSB first, one even-parity bit (XOR of the data bits), stop bit 1. The received word is held in an output register with a valid/ack handshake, plus parity, framing and overrun flags.

Parameters:
- WIDTH, 8, data bits per frame (2..15).

Ports:
- rx_clk  input  1  clock; all logic on rising edge.
- rx_reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idle high.
- rx_ack  input  1  host consumes data_out; single-cycle pulse or level.
- data_out  output  WIDTH  last received word.
- data_valid  output  1  data_out holds an unconsumed word.
- parity_err  output  1  parity mismatch on the word in data_out.
- frame_err  output  1  stop bit was 0 on the word in data_out.
- overrun  output  1  sticky: a word was overwritten before it was acked.
- rx_busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (async, rx_reset=0):
  - Both synchronizer flops go to 1, so there is no false start on release.
  - FSM goes to IDLE; shift register and bit counter go to 0.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, rx_busy=0.
  - Reset asserted mid-frame aborts the frame with no commit.
- Synchronizer: rx passes through two flops to give rx_s; the FSM sees only rx_s (2-cycle delay).
- FSM states IDLE, DATA, PARITY, STOP, BREAK:
  - IDLE: rx_s=0 → DATA, count=0. Otherwise stay.
  - DATA: each cycle shift_reg <= {rx_s, shift_reg[WIDTH-1:1]}. At count=WIDTH-1 go to PARITY; otherwise count+1.
  - PARITY: pe_next = rx_s ^ (^shift_reg) → STOP.
  - STOP: commit (see below). rx_s=1 → IDLE; rx_s=0 → BREAK.
  - BREAK: wait for rx_s=1, then → IDLE. No start is detected in BREAK.
- Commit, on the STOP edge:
  - data_out <= shift_reg, data_valid <= 1, parity_err <= pe_next, frame_err <= ~rx_s.
  - overrun <= overrun | (data_valid & ~rx_ack).
  - A frame with an error is still committed, with its flag set.
- Latency: if the start bit is sampled on rx at edge E0, data_valid is high after edge E0+WIDTH+4 (E0+12 for WIDTH=8). The frame occupies WIDTH+3 line bits.
- Back-to-back frames: the stop bit may be followed immediately by the next start bit. IDLE is entered on the commit edge and detects the new start the next cycle. There are no lost bits at a continuous 1-bit/clock rate with a single idle bit between frames.
- Handshake:
  - rx_ack with data_valid=1 and no commit on that edge: data_valid <= 0, overrun <= 0. data_out, parity_err and frame_err hold.
  - rx_ack coincident with a commit: the commit wins. data_valid stays 1, the new word is loaded, and overrun is not set.
  - rx_ack with data_valid=0: no effect.
- rx_busy = (state != IDLE), registered-state decode.
- Glitch: a 1-cycle low pulse on rx is treated as a start bit. The frame completes and reports frame_err if the stop bit is low. No glitch filtering is performed.

Test Plan:
- Reset, then rx held at 1 for 20 cycles → data_valid=0, rx_busy=0, all flags 0.
- Frame 0xA5, parity bit 0, stop 1, start sampled at E0 → data_valid rises after E0+12; data_out=0xA5, parity_err=0, frame_err=0. Then rx_ack pulse → data_valid=0 next edge.
- Frame 0x01 with parity bit 0 (wrong; correct is 1) → data_out=0x01, parity_err=1, frame_err=0.
- Frame 0x3C with stop bit 0, rx held low 5 more cycles then high → frame_err=1, FSM held in BREAK (rx_busy=1) until rx_s=1, no spurious second word.
- Two back-to-back frames 0x11 then 0x22, no ack → data_out=0x22, overrun=1. Ack → overrun=0, data_valid=0. Repeat with rx_ack asserted on the second commit edge → data_out=0x22, data_valid=1, overrun=0.
- rx_reset pulsed low at the 4th data bit of a frame → all outputs at reset values immediately. With rx high after release, no word is committed. A subsequent frame 0x5A is received correctly.
